udp_tx_csum_sf: RTL

- Store-and-forward UDP TX block with a parametrised datapath width. It buffers one payload frame and computes the UDP length and RFC 768 checksum over the pseudo-header, the UDP header and the byte-masked payload.
- When the computation is done, it presents a complete UDP header (ports, length, checksum), then replays the buffered payload.
- Sits between the application stream and the IP TX encapsulator, so downstream logic receives a finished header before any payload.
- Adds wide-bus/tkeep support, a checksum bypass mode, zero-checksum mapping and oversize-frame drop.

---
 rtl/udp_tx_csum_sf.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_csum_sf.sv
// Store-and-forward UDP TX: buffers one payload frame, computes UDP length and checksum,
// then presents the finished header followed by the replayed payload.
//
// state      | meaning
// S_IDLE     | waiting for header / pseudo-header fields
// S_PAYLOAD  | buffering payload, accumulating checksum and byte count
// S_FOLD1    | add length terms, first end-around fold
// S_FOLD2    | second fold, latch length and checksum
// S_HDR_OUT  | presenting header until accepted
// S_DATA_OUT | replaying buffered payload
module udp_tx_csum_sf #(
    parameter int DATA_WIDTH  = 8,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int MAX_PAYLOAD = 1472,
    parameter bit CSUM_EN     = 1'b1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  s_hdr_tvalid,
    output logic                  s_hdr_trdy,
    input  logic [15:0]           s_udp_src_port,
    input  logic [15:0]           s_udp_dst_port,
    input  logic [31:0]           s_ip_src_ip_addr,
    input  logic [31:0]           s_ip_dst_ip_addr,
    input  logic [7:0]            s_ip_protocol,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_trdy,
    output logic                  m_hdr_tvalid,
    input  logic                  m_hdr_trdy,
    output logic [15:0]           m_udp_src_port,
    output logic [15:0]           m_udp_dst_port,
    output logic [15:0]           m_udp_length,
    output logic [15:0]           m_udp_checksum,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_trdy,
    output logic                  o_drop
);
    localparam int DEPTH = (MAX_PAYLOAD + KEEP_WIDTH - 1) / KEEP_WIDTH;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int MW    = DATA_WIDTH + KEEP_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PAYLOAD, S_FOLD1, S_FOLD2, S_HDR_OUT, S_DATA_OUT
    } state_t;

    state_t state, state_nxt;

    logic [15:0]   byte_count, keep_cnt, new_count, len8;
    logic [31:0]   acc, seed, beat_sum, fold1_in, fold1;
    logic [15:0]   fold2, csum_raw, csum;
    logic          drop_flag, overflow, wr_en;
    logic          hdr_fire, beat_fire, mhdr_fire, mbeat_fire;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [MW-1:0] mem [DEPTH];
    logic [MW-1:0] rd_word;

    assign hdr_fire   = s_hdr_tvalid & s_hdr_trdy;
    assign beat_fire  = s_axis_tvalid & s_axis_trdy;
    assign mhdr_fire  = m_hdr_tvalid & m_hdr_trdy;
    assign mbeat_fire = m_axis_tvalid & m_axis_trdy;

    assign seed = {16'd0, s_ip_src_ip_addr[31:16]} + {16'd0, s_ip_src_ip_addr[15:0]}
                + {16'd0, s_ip_dst_ip_addr[31:16]} + {16'd0, s_ip_dst_ip_addr[15:0]}
                + {24'd0, s_ip_protocol} + {16'd0, s_udp_src_port} + {16'd0, s_udp_dst_port};

    always_comb begin
        keep_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            keep_cnt = keep_cnt + 16'(s_axis_tkeep[i]);
        end
    end

    assign new_count = byte_count + keep_cnt;
    assign overflow  = (32'(new_count) > 32'(MAX_PAYLOAD));
    assign wr_en     = beat_fire & ~drop_flag & ~overflow;

    generate
        if (DATA_WIDTH == 8) begin : g_narrow
            // Byte bus: pair consecutive bytes; an unpaired final byte is the high half.
            logic       phase;
            logic [7:0] held;
            logic [7:0] lane0;

            assign lane0 = s_axis_tdata[7:0] & {8{s_axis_tkeep[0]}};

            always_comb begin
                beat_sum = '0;
                if (phase) begin
                    beat_sum = {16'd0, held, lane0};
                end else if (s_axis_tlast) begin
                    beat_sum = {16'd0, lane0, 8'h00};
                end
            end

            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    phase <= 1'b0;
                    held  <= 8'h00;
                end else if (hdr_fire) begin
                    phase <= 1'b0;
                end else if (beat_fire) begin
                    phase <= ~phase;
                    held  <= lane0;
                end
            end
        end else begin : g_wide
            always_comb begin
                beat_sum = '0;
                for (int i = 0; i < KEEP_WIDTH / 2; i++) begin
                    beat_sum = beat_sum + {16'd0,
                        s_axis_tdata[16*i +: 8]   & {8{s_axis_tkeep[2*i]}},
                        s_axis_tdata[16*i+8 +: 8] & {8{s_axis_tkeep[2*i+1]}}};
                end
            end
        end
    endgenerate

    // Length appears in both the pseudo-header and the UDP header, hence the doubling.
    assign len8     = byte_count + 16'd8;
    assign fold1_in = acc + {15'd0, len8, 1'b0};
    assign fold1    = {16'd0, fold1_in[15:0]} + {16'd0, fold1_in[31:16]};
    assign fold2    = acc[15:0] + acc[31:16];
    assign csum_raw = ~fold2;
    assign csum     = !CSUM_EN ? 16'h0000 : ((csum_raw == 16'h0000) ? 16'hFFFF : csum_raw);

    assign rd_word = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (hdr_fire) state_nxt = S_PAYLOAD;
            S_PAYLOAD:  if (beat_fire && s_axis_tlast)
                            state_nxt = (drop_flag || overflow) ? S_IDLE : S_FOLD1;
            S_FOLD1:    state_nxt = S_FOLD2;
            S_FOLD2:    state_nxt = S_HDR_OUT;
            S_HDR_OUT:  if (mhdr_fire) state_nxt = S_DATA_OUT;
            S_DATA_OUT: if (mbeat_fire && m_axis_tlast) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        s_hdr_trdy   = (state == S_IDLE);
        s_axis_trdy  = (state == S_PAYLOAD);
        m_hdr_tvalid = (state == S_HDR_OUT);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_count     <= '0;
            acc            <= '0;
            drop_flag      <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            o_drop         <= 1'b0;
            m_udp_src_port <= '0;
            m_udp_dst_port <= '0;
            m_udp_length   <= '0;
            m_udp_checksum <= '0;
            m_axis_tdata   <= '0;
            m_axis_tkeep   <= '0;
            m_axis_tlast   <= 1'b0;
            m_axis_tvalid  <= 1'b0;
        end else begin
            o_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hdr_fire) begin
                        m_udp_src_port <= s_udp_src_port;
                        m_udp_dst_port <= s_udp_dst_port;
                        acc            <= seed;
                        byte_count     <= '0;
                        drop_flag      <= 1'b0;
                        wr_ptr         <= '0;
                        rd_ptr         <= '0;
                    end
                end
                S_PAYLOAD: begin
                    if (wr_en) begin
                        wr_ptr     <= wr_ptr + 1'b1;
                        byte_count <= new_count;
                        acc        <= acc + beat_sum;
                    end
                    if (beat_fire && overflow) begin
                        drop_flag <= 1'b1;
                    end
                    if (beat_fire && s_axis_tlast && (drop_flag || overflow)) begin
                        o_drop <= 1'b1;
                    end
                end
                S_FOLD1: acc <= fold1;
                S_FOLD2: begin
                    acc            <= {16'd0, fold2};
                    m_udp_length   <= len8;
                    m_udp_checksum <= csum;
                end
                S_HDR_OUT: begin
                    if (mhdr_fire) begin
                        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_word;
                        m_axis_tvalid <= 1'b1;
                        rd_ptr        <= rd_ptr + 1'b1;
                    end
                end
                S_DATA_OUT: begin
                    if (mbeat_fire) begin
                        if (m_axis_tlast) begin
                            m_axis_tvalid <= 1'b0;
                        end else begin
                            {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= rd_word;
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
